// File: rtl/rx_frame_arbiter.sv
// Round-robin frame arbiter feeding one analysis engine from two GMII nibble ports, 1-cycle registered latency.
// No buffering: ungrantable frames are dropped and counted. Define RUNT_CHECK_EN to flag/count runt frames.
module rx_frame_arbiter #(
  parameter int MAX_NIBBLES = 3036,
`ifdef RUNT_CHECK_EN
  parameter int MIN_NIBBLES = 128,
`endif
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_sop,
  input  logic             p0_dv,
  input  logic [3:0]       p0_data,
  input  logic             p0_eop,
  input  logic             p1_sop,
  input  logic             p1_dv,
  input  logic [3:0]       p1_data,
  input  logic             p1_eop,
  input  logic             eng_ready,
  output logic             m_sop,
  output logic             m_dv,
  output logic [3:0]       m_data,
  output logic             m_eop,
  output logic             m_err,
  output logic             m_port,
  output logic [CNT_W-1:0] drop_cnt0,
  output logic [CNT_W-1:0] drop_cnt1,
  output logic [CNT_W-1:0] trunc_cnt
`ifdef RUNT_CHECK_EN
  ,
  output logic [CNT_W-1:0] runt_cnt
`endif
);

  localparam int NW = $clog2(MAX_NIBBLES + 1);
  localparam logic [NW-1:0] MAX_C = NW'(MAX_NIBBLES);

  typedef enum logic [1:0] {IDLE, FWD, TRUNC, GAP} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            m_sop_q, m_sop_d, m_dv_q, m_dv_d, m_eop_q, m_eop_d;
  logic            m_err_q, m_err_d, m_port_q, m_port_d;
  logic [3:0]      m_data_q, m_data_d;
  logic [CNT_W-1:0] drop0_q, drop1_q, trunc_q;
  logic            drop0_inc, drop1_inc, trunc_inc, runt_inc;
  logic            pick;

  // m_port_q doubles as the granted-port selector while a frame is active
  logic       g_sop, g_dv, g_eop;
  logic [3:0] g_data;
  assign g_sop  = m_port_q ? p1_sop  : p0_sop;
  assign g_dv   = m_port_q ? p1_dv   : p0_dv;
  assign g_eop  = m_port_q ? p1_eop  : p0_eop;
  assign g_data = m_port_q ? p1_data : p0_data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_sop_d      = 1'b0;
    m_dv_d       = 1'b0;
    m_data_d     = 4'h0;
    m_eop_d      = 1'b0;
    m_err_d      = 1'b0;
    m_port_d     = m_port_q;
    drop0_inc    = 1'b0;
    drop1_inc    = 1'b0;
    trunc_inc    = 1'b0;
    runt_inc     = 1'b0;
    pick         = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_sop || p1_sop) begin
          if (!eng_ready) begin
            drop0_inc = p0_sop;
            drop1_inc = p1_sop;
          end else begin
            pick         = (p0_sop && p1_sop) ? ~last_grant_q : p1_sop;
            drop0_inc    = p0_sop && pick;
            drop1_inc    = p1_sop && !pick;
            last_grant_d = pick;
            m_port_d     = pick;
            m_sop_d      = 1'b1;
            m_dv_d       = 1'b1;
            m_data_d     = pick ? p1_data : p0_data;
            cnt_d        = NW'(1);
            state_d      = FWD;
          end
        end
      end
      FWD: begin
        // any sop here is either the other port (no grant) or an abort of our own frame
        drop0_inc = p0_sop;
        drop1_inc = p1_sop;
        if (g_sop) begin
          m_eop_d   = 1'b1;
          m_err_d   = 1'b1;
          trunc_inc = 1'b1;
          state_d   = GAP;
        end else if (g_eop) begin
          m_eop_d = 1'b1;
`ifdef RUNT_CHECK_EN
          runt_inc = (cnt_q < NW'(MIN_NIBBLES));
          m_err_d  = runt_inc;
`endif
          state_d = GAP;
        end else if (g_dv) begin
          if (cnt_q == MAX_C) begin
            m_eop_d   = 1'b1;
            m_err_d   = 1'b1;
            trunc_inc = 1'b1;
            state_d   = TRUNC;
          end else begin
            m_dv_d   = 1'b1;
            m_data_d = g_data;
            cnt_d    = cnt_q + NW'(1);
          end
        end
      end
      TRUNC: begin
        drop0_inc = p0_sop;
        drop1_inc = p1_sop;
        if (g_sop || g_eop) state_d = GAP;
      end
      GAP: begin
        drop0_inc = p0_sop;
        drop1_inc = p1_sop;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      m_sop_q      <= 1'b0;
      m_dv_q       <= 1'b0;
      m_data_q     <= 4'h0;
      m_eop_q      <= 1'b0;
      m_err_q      <= 1'b0;
      m_port_q     <= 1'b0;
      drop0_q      <= '0;
      drop1_q      <= '0;
      trunc_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_sop_q      <= m_sop_d;
      m_dv_q       <= m_dv_d;
      m_data_q     <= m_data_d;
      m_eop_q      <= m_eop_d;
      m_err_q      <= m_err_d;
      m_port_q     <= m_port_d;
      if (drop0_inc && drop0_q != '1) drop0_q <= drop0_q + CNT_W'(1);
      if (drop1_inc && drop1_q != '1) drop1_q <= drop1_q + CNT_W'(1);
      if (trunc_inc && trunc_q != '1) trunc_q <= trunc_q + CNT_W'(1);
    end
  end

`ifdef RUNT_CHECK_EN
  logic [CNT_W-1:0] runt_q;
  always_ff @(posedge clk) begin
    if (reset) runt_q <= '0;
    else if (runt_inc && runt_q != '1) runt_q <= runt_q + CNT_W'(1);
  end
  assign runt_cnt = runt_q;
`else
  logic unused_runt;
  assign unused_runt = runt_inc;
`endif

  assign m_sop     = m_sop_q;
  assign m_dv      = m_dv_q;
  assign m_data    = m_data_q;
  assign m_eop     = m_eop_q;
  assign m_err     = m_err_q;
  assign m_port    = m_port_q;
  assign drop_cnt0 = drop0_q;
  assign drop_cnt1 = drop1_q;
  assign trunc_cnt = trunc_q;

endmodule

// File: doc/rx_frame_arbiter.md
Name: rx_frame_arbiter

Overview:
- Frame-level arbiter sharing one downstream packet analysis engine between two 4-bit GMII RX front ends (port 0, port 1).
- Grants the engine to one port per frame, round-robin, and forwards that frame's nibble stream with a fixed 1-cycle latency.
- Frames that cannot be granted are dropped and counted; there is no buffering.
- Also enforces the maximum frame length by truncating oversize frames with an error flag.

Parameters:
- MAX_NIBBLES, 3036: maximum forwarded data nibbles per frame (1518 bytes).
- MIN_NIBBLES, 128: runt threshold (64 bytes); used only with RUNT_CHECK_EN.
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- p0_sop  in  1  pulse on port 0's first data nibble (p0_dv=1 in the same cycle).
- p0_dv  in  1  port 0 data nibble valid.
- p0_data  in  4  port 0 nibble.
- p0_eop  in  1  port 0 end-of-frame pulse, in a cycle with p0_dv=0.
- p1_sop, p1_dv, p1_data, p1_eop: same as port 0, for port 1.
- eng_ready  in  1  engine can accept a new frame; sampled only at grant time.
- m_sop  out  1  first forwarded nibble.
- m_dv  out  1  forwarded nibble valid.
- m_data  out  4  forwarded nibble.
- m_eop  out  1  end-of-frame pulse, with m_dv=0.
- m_err  out  1  qualifies m_eop: frame truncated, aborted or runt.
- m_port  out  1  source port of the current or last frame.
- drop_cnt0  out  CNT_W  port 0 frames dropped, saturating.
- drop_cnt1  out  CNT_W  port 1 frames dropped, saturating.
- trunc_cnt  out  CNT_W  frames truncated or aborted, saturating.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - last_grant is 1, so port 0 wins the first tie.
  - Nibble counter is 0.
- Reset asserted mid-frame: the frame is abandoned with no m_eop and no counter update.
- Latency: every m_* output is registered, exactly 1 cycle after the causing input.
- IDLE:
  - sop on one port and eng_ready=1: grant that port, forward its first nibble with m_sop=1, go to FWD.
  - sop on both ports in the same cycle with eng_ready=1: grant ~last_grant; the loser is dropped (its drop_cnt +1).
  - sop with eng_ready=0: every sop'ing port is dropped and counted; stay in IDLE.
  - On grant: last_grant and m_port take the granted port.
- FWD:
  - Each granted-port dv nibble is forwarded (m_dv=1, m_data=nibble) and the counter increments.
  - Granted eop: m_eop=1, m_err=0; go to GAP.
  - dv nibble arriving when the counter already equals MAX_NIBBLES: the nibble is not forwarded; m_eop=1, m_err=1; trunc_cnt +1; go to TRUNC.
  - Granted-port sop without a preceding eop (abort): m_eop=1, m_err=1; trunc_cnt +1; the new frame is dropped (drop_cnt +1); go to GAP.
- TRUNC: discard the granted port's nibbles until its eop, then go to GAP. No m_* activity.
- GAP: exactly one cycle with all m_* at 0 and the counter cleared, then IDLE.
- Any state other than IDLE:
  - A sop on the non-granted port is dropped and counted.
  - The non-granted port's dv and eop are ignored.
  - In GAP a sop on either port is dropped and counted.
- Counters: increment by at most 1 per cycle each; hold at 2^CNT_W-1.
- Both ports dropped in the same cycle: both drop counters increment in that cycle.
- m_eop and m_sop never assert in the same cycle. m_dv=0 whenever m_eop=1.

Optional Feature:
- Macro: RUNT_CHECK_EN.
- Defined:
  - At a normal eop in FWD with counter < MIN_NIBBLES, m_eop is accompanied by m_err=1.
  - Adds output runt_cnt (CNT_W, saturating, reset 0), incremented on each runt.
- Not defined:
  - No runt_cnt port.
  - Normal eop always gives m_err=0 regardless of length.

Test Plan:
- Port 0 sends a frame: sop + 16 nibbles 0x5..0xD pattern, eng_ready=1. Required: m_sop 1 cycle after p0_sop; identical 16 nibbles on m_data; m_eop=1, m_err=0, m_port=0; drop counters stay 0.
- p0_sop and p1_sop in the same cycle after reset. Required: port 0 granted and drop_cnt1=1. Repeat after GAP: port 1 granted and drop_cnt0=1.
- eng_ready=0 at p1_sop. Required: no m_* activity; drop_cnt1 increments by 1; next frame with eng_ready=1 is forwarded.
- Port 0 frame of 3040 nibbles. Required: exactly 3036 nibbles forwarded; m_eop with m_err=1 in the cycle after nibble 3037 arrives; trunc_cnt=1; remaining nibbles suppressed until p0_eop; GAP then IDLE.
- p0 sop, 10 nibbles, then a second p0_sop with no eop. Required: m_eop with m_err=1; trunc_cnt=1; drop_cnt0=1.
- Reset asserted at nibble 5 of a frame. Required: all outputs 0 next cycle; the following p1 frame is granted normally with m_port=1. With RUNT_CHECK_EN, a 20-nibble frame gives m_err=1 on m_eop and runt_cnt=1.
